data_cache_dm: RTL and testbench

//  Parametrised direct-mapped, write-through, no-write-allocate, blocking data cache between the MEM stage and a

---
 rtl/dcache_pkg.sv | 31 +++
 rtl/data_cache_dm_if.sv | 21 ++
 rtl/dcache_array.sv | 47 ++++
 rtl/data_cache_dm.sv | 189 ++++++++++++++++++
 tb/tb_data_cache_dm.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped data cache: FSM states, pipeline
// MEM op encodings and helpers that derive the address-field widths from the
// cache geometry.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    WRITE
  } state_e;

  localparam logic [1:0] MEM_RD = 2'b01;
  localparam logic [1:0] MEM_WR = 2'b10;

  // Word-offset field width (0 when a line holds a single word).
  function automatic int unsigned off_w(input int unsigned line_words);
    return (line_words > 1) ? $clog2(line_words) : 0;
  endfunction

  // Line-index field width.
  function automatic int unsigned idx_w(input int unsigned num_lines);
    return $clog2(num_lines);
  endfunction

  // Tag width: whatever remains of the word address.
  function automatic int unsigned tag_w(input int unsigned num_lines,
                                        input int unsigned line_words);
    return 30 - off_w(line_words) - idx_w(num_lines);
  endfunction

endpackage

// File: rtl/data_cache_dm_if.sv
// Word-wide backing-memory port of the data cache.
//   mem_req/mem_we/mem_addr/mem_wdata : request, driven by the cache (master)
//   mem_rdata/mem_ack                 : response, driven by memory (slave)
interface data_cache_dm_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/dcache_array.sv
// Valid/tag/data storage of the direct-mapped cache.
//   rd_idx/rd_waddr      : async read port (line index, {idx,off} word address)
//   rd_valid/rd_tag/rd_data : read results
//   lw_en/lw_idx/lw_tag  : line completion write (sets tag and valid)
//   ww_en/ww_waddr/ww_data : single word write
//   rst                  : asynchronously clears all valid bits
module dcache_array #(
  parameter int unsigned NUM_LINES  = 64,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned IDX_W      = 6,
  parameter int unsigned AW         = 8,
  parameter int unsigned TAG_W      = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [AW-1:0]    rd_waddr,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             lw_en,
  input  logic [IDX_W-1:0] lw_idx,
  input  logic [TAG_W-1:0] lw_tag,
  input  logic             ww_en,
  input  logic [AW-1:0]    ww_waddr,
  input  logic [31:0]      ww_data
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES*LINE_WORDS];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_waddr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else if (lw_en) valid_q[lw_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (lw_en) tag_q[lw_idx] <= lw_tag;
    if (ww_en) data_q[ww_waddr] <= ww_data;
  end

endmodule

// File: rtl/data_cache_dm.sv
// Direct-mapped, write-through, no-write-allocate, blocking data cache.
//   clk, rst          : clock, asynchronous active-high reset
//   MEM/Addr/Wdata    : pipeline access (MEM[0]=read, MEM[1]=write, 11=write)
//   Rdata/stall       : load data (combinational on hit), pipeline hold
//   mem_bus           : backing-memory request/ack port (master side)
//   hit_cnt/miss_cnt  : wrapping hit and read-miss counters
module data_cache_dm
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_LINES  = 64,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        MEM,
  input  logic [31:0]       Addr,
  input  logic [31:0]       Wdata,
  output logic [31:0]       Rdata,
  output logic              stall,
  data_cache_dm_if.master   mem_bus,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int unsigned OFF_W = off_w(LINE_WORDS);
  localparam int unsigned IDX_W = idx_w(NUM_LINES);
  localparam int unsigned TAG_W = tag_w(NUM_LINES, LINE_WORDS);
  localparam int unsigned AW    = OFF_W + IDX_W;
  localparam int unsigned OB    = (OFF_W > 0) ? OFF_W : 1;
  localparam logic [OB-1:0] LAST_BEAT = OB'(LINE_WORDS - 1);
  localparam logic [31:0]   LINE_MASK = ~32'((LINE_WORDS * 4) - 1);

  state_e           state_q, state_d;
  logic [OB-1:0]    beat_q, beat_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_data;
  logic             lw_en, ww_en;
  logic [AW-1:0]    ww_waddr;
  logic [31:0]      ww_data;
  logic             hit, is_rd, is_wr, ack;
  logic             unused_addr;

  assign unused_addr = ^Addr[1:0];
  assign is_wr = MEM[1];
  assign is_rd = (MEM == MEM_RD);
  assign hit   = rd_valid && (rd_tag == Addr[31 -: TAG_W]);
  assign ack   = mem_bus.mem_ack && mem_req_q;

  dcache_array #(
    .NUM_LINES (NUM_LINES),
    .LINE_WORDS(LINE_WORDS),
    .IDX_W     (IDX_W),
    .AW        (AW),
    .TAG_W     (TAG_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (Addr[2+OFF_W +: IDX_W]),
    .rd_waddr(Addr[2 +: AW]),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .lw_en   (lw_en),
    .lw_idx  (mem_addr_q[2+OFF_W +: IDX_W]),
    .lw_tag  (mem_addr_q[31 -: TAG_W]),
    .ww_en   (ww_en),
    .ww_waddr(ww_waddr),
    .ww_data (ww_data)
  );

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    stall       = 1'b0;
    Rdata       = '0;
    lw_en       = 1'b0;
    ww_en       = 1'b0;
    ww_waddr    = Addr[2 +: AW];
    ww_data     = Wdata;

    unique case (state_q)
      IDLE: begin
        if (is_wr) begin
          stall       = 1'b1;
          ww_en       = hit;
          hit_cnt_d   = hit ? hit_cnt_q + CNT_W'(1) : hit_cnt_q;
          mem_addr_d  = {Addr[31:2], 2'b00};
          mem_wdata_d = Wdata;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          state_d     = WRITE;
        end else if (is_rd) begin
          if (hit) begin
            Rdata     = rd_data;
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
          end else begin
            stall      = 1'b1;
            mem_addr_d = Addr & LINE_MASK;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            beat_d     = '0;
            miss_cnt_d = miss_cnt_q + CNT_W'(1);
            state_d    = REFILL;
          end
        end
      end
      REFILL: begin
        stall = 1'b1;
        if (ack) begin
          // mem_addr_q walks the line, so its low bits are {idx,beat}.
          ww_en    = 1'b1;
          ww_waddr = mem_addr_q[2 +: AW];
          ww_data  = mem_bus.mem_rdata;
          if (beat_q == LAST_BEAT) begin
            lw_en     = 1'b1;
            mem_req_d = 1'b0;
            beat_d    = '0;
            state_d   = IDLE;
          end else begin
            beat_d     = beat_q + OB'(1);
            mem_addr_d = mem_addr_q + 32'd4;
          end
        end
      end
      WRITE: begin
        stall = !ack;
        if (ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset abandons any transfer without touching the arrays.
    if (rst) begin
      stall = 1'b0;
      Rdata = '0;
      lw_en = 1'b0;
      ww_en = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign mem_bus.mem_req   = mem_req_q;
  assign mem_bus.mem_we    = mem_we_q;
  assign mem_bus.mem_addr  = mem_addr_q;
  assign mem_bus.mem_wdata = mem_wdata_q;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_data_cache_dm.sv
// Bench for data_cache_dm: directed vector table, hand-written multi-cycle
// sequences and randomized accesses against a line-level reference model.
module tb_data_cache_dm;
  localparam int unsigned NL = 64;
  localparam int unsigned LW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  MEM;
  logic [31:0] Addr, Wdata, Rdata;
  logic        stall;
  logic [31:0] hit_cnt, miss_cnt;

  data_cache_dm_if mbus();

  data_cache_dm #(.NUM_LINES(NL), .LINE_WORDS(LW), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .MEM(MEM), .Addr(Addr), .Wdata(Wdata),
    .Rdata(Rdata), .stall(stall), .mem_bus(mbus),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- backing memory with configurable ack latency -----------
  int unsigned lat  = 0;
  int unsigned wcnt = 0;
  logic [31:0] bmem [logic [31:0]];
  logic [31:0] log_a [$];
  logic [31:0] log_d [$];
  logic        log_we [$];

  always_comb mbus.mem_ack = mbus.mem_req && (wcnt == lat);

  always @(negedge clk)
    mbus.mem_rdata = bmem.exists(mbus.mem_addr) ? bmem[mbus.mem_addr]
                                                : (mbus.mem_addr ^ 32'hA5A5_0000);

  always @(posedge clk) begin
    if (mbus.mem_req && mbus.mem_ack) begin
      if (mbus.mem_we) bmem[mbus.mem_addr] = mbus.mem_wdata;
      log_a.push_back(mbus.mem_addr);
      log_d.push_back(mbus.mem_wdata);
      log_we.push_back(mbus.mem_we);
      wcnt <= 0;
    end else if (mbus.mem_req) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
    end
  end

  // ---------------- reference model (line granularity) ----------------------
  logic        mv [NL];
  logic [31:0] mt [NL];
  logic [31:0] mmem [logic [31:0]];
  int unsigned ehit = 0;
  int unsigned emiss = 0;

  function automatic logic [31:0] mread(input logic [31:0] a);
    return mmem.exists(a) ? mmem[a] : (a ^ 32'hA5A5_0000);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NL; i++) mv[i] = 1'b0;
    ehit = 0;
    emiss = 0;
  endtask

  task automatic model_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] wd, input int unsigned l,
                          output logic [31:0] er, output int es, output int en);
    int unsigned line;
    logic [31:0] tg;
    logic        h;
    line = (a / (LW * 4)) % NL;
    tg   = a / (LW * 4 * NL);
    h    = mv[line] && (mt[line] == tg);
    er = '0; es = 0; en = 0;
    if (op[1]) begin
      es = 1 + l;
      en = 1;
      if (h) ehit++;
      mmem[a] = wd;
    end else if (op[0]) begin
      if (!h) begin
        es = LW * (l + 1) + 1;
        en = LW;
        emiss++;
        mv[line] = 1'b1;
        mt[line] = tg;
      end
      ehit++;
      er = mread(a);
    end
  endtask

  // ---------------- checking helpers ----------------------------------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Applies one access at #1 after a rising edge and holds it until stall drops.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input int unsigned l, output logic [31:0] rd, output int stalls);
    bit done;
    lat = l;
    log_a.delete(); log_d.delete(); log_we.delete();
    MEM = op; Addr = a; Wdata = wd;
    stalls = 0; rd = '0; done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (!stall) begin rd = Rdata; done = 1; end
      else stalls++;
    end
    if (!done) stalls = -1;
    @(posedge clk); #1;
    MEM = 2'b00;
  endtask

  task automatic run_check(input string nm, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] wd, input int unsigned l,
                           input logic [31:0] er, input int es, input int en,
                           input int unsigned eh, input int unsigned em);
    logic [31:0] rd;
    int st;
    logic [31:0] ea;
    do_op(op, a, wd, l, rd, st);
    chk($sformatf("%s.rdata", nm), rd, er);
    chk($sformatf("%s.stalls", nm), st, es);
    chk($sformatf("%s.nreq", nm), log_a.size(), en);
    chk($sformatf("%s.hit_cnt", nm), hit_cnt, eh);
    chk($sformatf("%s.miss_cnt", nm), miss_cnt, em);
    for (int k = 0; k < en && k < log_a.size(); k++) begin
      ea = op[1] ? a : ((a & ~32'(LW * 4 - 1)) + 32'(4 * k));
      chk($sformatf("%s.addr%0d", nm, k), log_a[k], ea);
      chk($sformatf("%s.we%0d", nm, k), {31'd0, log_we[k]}, {31'd0, op[1]});
      if (op[1]) chk($sformatf("%s.wdata", nm), log_d[k], wd);
    end
  endtask

  typedef struct {
    int unsigned lat;
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] er;
    int          es;
    int          en;
    int unsigned eh;
    int unsigned em;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] er;
    int es, en, st;
    logic [31:0] rd, a, wd;
    logic [1:0] op;
    int unsigned l, r;
    bit seen;

    tbl[0]  = '{2, 2'b01, 32'h100,  32'h0,         32'hA5A5_0100, 13, 4, 1, 1};
    tbl[1]  = '{2, 2'b01, 32'h104,  32'h0,         32'hA5A5_0104,  0, 0, 2, 1};
    tbl[2]  = '{0, 2'b10, 32'h108,  32'hDEAD_BEEF, 32'h0,          1, 1, 3, 1};
    tbl[3]  = '{0, 2'b01, 32'h108,  32'h0,         32'hDEAD_BEEF,  0, 0, 4, 1};
    tbl[4]  = '{1, 2'b10, 32'h2000, 32'h1234,      32'h0,          2, 1, 4, 1};
    tbl[5]  = '{1, 2'b01, 32'h2000, 32'h0,         32'h1234,       9, 4, 5, 2};
    tbl[6]  = '{0, 2'b01, 32'h100,  32'h0,         32'hA5A5_0100,  0, 0, 6, 2};
    tbl[7]  = '{0, 2'b01, 32'h500,  32'h0,         32'hA5A5_0500,  5, 4, 7, 3};
    tbl[8]  = '{3, 2'b01, 32'h100,  32'h0,         32'hA5A5_0100, 17, 4, 8, 4};
    tbl[9]  = '{0, 2'b01, 32'h108,  32'h0,         32'hDEAD_BEEF,  0, 0, 9, 4};
    tbl[10] = '{0, 2'b00, 32'h104,  32'h0,         32'h0,          0, 0, 9, 4};
    tbl[11] = '{2, 2'b11, 32'h104,  32'h5555_AAAA, 32'h0,          3, 1, 10, 4};
    tbl[12] = '{0, 2'b01, 32'h104,  32'h0,         32'h5555_AAAA,  0, 0, 11, 4};

    model_clear();

    // Reset behaviour with a read presented during reset.
    rst = 1'b1; MEM = 2'b01; Addr = 32'h100; Wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.stall", {31'd0, stall}, 32'd0);
    chk("reset.rdata", Rdata, 32'd0);
    chk("reset.mem_req", {31'd0, mbus.mem_req}, 32'd0);
    chk("reset.hit_cnt", hit_cnt, 32'd0);
    chk("reset.miss_cnt", miss_cnt, 32'd0);
    MEM = 2'b00; rst = 1'b0;
    @(negedge clk);
    chk("reset.mem_addr", mbus.mem_addr, 32'd0);
    chk("reset.mem_wdata", mbus.mem_wdata, 32'd0);
    chk("reset.mem_we", {31'd0, mbus.mem_we}, 32'd0);
    @(posedge clk); #1;

    // Directed vector table.
    for (int i = 0; i < 13; i++) begin
      model_op(tbl[i].op, tbl[i].addr, tbl[i].wd, tbl[i].lat, er, es, en);
      run_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].addr, tbl[i].wd, tbl[i].lat,
                tbl[i].er, tbl[i].es, tbl[i].en, tbl[i].eh, tbl[i].em);
    end

    // Write whose inputs change during the stall: latched values must go out.
    model_op(2'b10, 32'h200, 32'hCAFE_F00D, 3, er, es, en);
    lat = 3;
    log_a.delete(); log_d.delete(); log_we.delete();
    MEM = 2'b10; Addr = 32'h200; Wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    MEM = 2'b01; Addr = 32'h104; Wdata = 32'h0;
    st = 1; seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (!stall) seen = 1;
      else st++;
    end
    @(posedge clk); #1;
    MEM = 2'b00;
    chk("hold.stalls", st, es);
    chk("hold.nreq", log_a.size(), 1);
    if (log_a.size() > 0) begin
      chk("hold.addr", log_a[0], 32'h200);
      chk("hold.wdata", log_d[0], 32'hCAFE_F00D);
    end
    chk("hold.hit_cnt", hit_cnt, ehit);
    @(posedge clk); #1;

    // Reset during beat 2 of a refill.
    lat = 1;
    log_a.delete(); log_d.delete(); log_we.delete();
    MEM = 2'b01; Addr = 32'h4000; Wdata = '0;
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (log_a.size() == 2) seen = 1;
    end
    chk("rstmid.reach_beat2", log_a.size(), 2);
    rst = 1'b1;
    #1;
    chk("rstmid.mem_req", {31'd0, mbus.mem_req}, 32'd0);
    chk("rstmid.stall", {31'd0, stall}, 32'd0);
    chk("rstmid.rdata", Rdata, 32'd0);
    chk("rstmid.miss_cnt", miss_cnt, 32'd0);
    @(posedge clk); #1;
    MEM = 2'b00; rst = 1'b0;
    @(posedge clk); #1;
    model_clear();
    model_op(2'b01, 32'h4000, 32'h0, 1, er, es, en);
    run_check("rstmid.refill", 2'b01, 32'h4000, 32'h0, 1, er, es, en, ehit, emiss);

    // Randomized accesses over a small, conflict-rich address window.
    for (int n = 0; n < 150; n++) begin
      r  = $urandom_range(0, 9);
      op = (r == 0) ? 2'b00 : (r <= 6) ? 2'b01 : (r == 9) ? 2'b11 : 2'b10;
      a  = 32'($urandom_range(0, 3) * NL * LW * 4 + $urandom_range(0, 3) * LW * 4
               + $urandom_range(0, LW - 1) * 4);
      wd = $urandom;
      l  = $urandom_range(0, 3);
      model_op(op, a, wd, l, er, es, en);
      run_check($sformatf("rnd%0d", n), op, a, wd, l, er, es, en, ehit, emiss);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
